// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel/line counters, frame-boundary config latch with
// validation, and delayed de/hsync/vsync strobes aligned to downstream pixel latency.
module video_timing_gen #(
  parameter int unsigned BIT_WIDTH  = 12,
  parameter int unsigned BIT_HEIGHT = 11,
  parameter int unsigned PIPE_LAT   = 2,
  parameter logic        SYNC_POL   = 1'b1
) (
  input  logic                  rtio_clk,
  input  logic                  rtio_resetn,
  input  logic                  en,
  input  logic [BIT_WIDTH-1:0]  h_active,
  input  logic [BIT_WIDTH-1:0]  h_fp,
  input  logic [BIT_WIDTH-1:0]  h_sync,
  input  logic [BIT_WIDTH-1:0]  h_bp,
  input  logic [BIT_HEIGHT-1:0] v_active,
  input  logic [BIT_HEIGHT-1:0] v_fp,
  input  logic [BIT_HEIGHT-1:0] v_sync,
  input  logic [BIT_HEIGHT-1:0] v_bp,
  output logic [BIT_WIDTH-1:0]  cx,
  output logic [BIT_HEIGHT-1:0] cy,
  output logic [BIT_WIDTH-1:0]  frame_width,
  output logic [BIT_HEIGHT-1:0] frame_height,
  output logic [BIT_WIDTH-1:0]  screen_width,
  output logic [BIT_HEIGHT-1:0] screen_height,
  output logic                  de,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  frame_start,
  output logic                  cfg_err
);

  localparam logic [BIT_WIDTH+1:0]  HMax    = {2'b00, {BIT_WIDTH{1'b1}}};
  localparam logic [BIT_HEIGHT+1:0] VMax    = {2'b00, {BIT_HEIGHT{1'b1}}};
  localparam logic [BIT_WIDTH-1:0]  HActRst = BIT_WIDTH'(1920);
  localparam logic [BIT_WIDTH-1:0]  HSsRst  = BIT_WIDTH'(2008);
  localparam logic [BIT_WIDTH-1:0]  HSeRst  = BIT_WIDTH'(2052);
  localparam logic [BIT_WIDTH-1:0]  HTotRst = BIT_WIDTH'(2200);
  localparam logic [BIT_HEIGHT-1:0] VActRst = BIT_HEIGHT'(1080);
  localparam logic [BIT_HEIGHT-1:0] VSsRst  = BIT_HEIGHT'(1084);
  localparam logic [BIT_HEIGHT-1:0] VSeRst  = BIT_HEIGHT'(1089);
  localparam logic [BIT_HEIGHT-1:0] VTotRst = BIT_HEIGHT'(1125);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e                state_q, state_d;
  logic [BIT_WIDTH-1:0]  cx_q, cx_d;
  logic [BIT_HEIGHT-1:0] cy_q, cy_d;
  // Latched config kept as thresholds: active end, sync start, sync end, total.
  logic [BIT_WIDTH-1:0]  h_act_q, h_act_d, h_ss_q, h_ss_d, h_se_q, h_se_d, h_tot_q, h_tot_d;
  logic [BIT_HEIGHT-1:0] v_act_q, v_act_d, v_ss_q, v_ss_d, v_se_q, v_se_d, v_tot_q, v_tot_d;
  logic                  cfg_err_q, cfg_err_d;

  logic [BIT_WIDTH+1:0]  h_sum;
  logic [BIT_HEIGHT+1:0] v_sum;
  logic                  cfg_ok, latch, h_last, v_last, run;

  assign h_sum = {2'b00, h_active} + {2'b00, h_fp} + {2'b00, h_sync} + {2'b00, h_bp};
  assign v_sum = {2'b00, v_active} + {2'b00, v_fp} + {2'b00, v_sync} + {2'b00, v_bp};
  assign cfg_ok = (h_active != '0) && (h_fp != '0) && (h_sync != '0) && (h_bp != '0) &&
                  (v_active != '0) && (v_fp != '0) && (v_sync != '0) && (v_bp != '0) &&
                  (h_sum <= HMax) && (v_sum <= VMax);

  assign h_last = (cx_q == h_tot_q - BIT_WIDTH'(1));
  assign v_last = (cy_q == v_tot_q - BIT_HEIGHT'(1));
  assign run    = (state_q == StRun);

  always_comb begin
    state_d   = state_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    h_act_d   = h_act_q;
    h_ss_d    = h_ss_q;
    h_se_d    = h_se_q;
    h_tot_d   = h_tot_q;
    v_act_d   = v_act_q;
    v_ss_d    = v_ss_q;
    v_se_d    = v_se_q;
    v_tot_d   = v_tot_q;
    cfg_err_d = cfg_err_q;
    latch     = 1'b0;
    unique case (state_q)
      StIdle: begin
        cx_d = '0;
        cy_d = '0;
        if (en) begin
          state_d = StRun;
          latch   = 1'b1;
        end
      end
      StRun: begin
        if (h_last) begin
          cx_d = '0;
          if (v_last) begin
            cy_d  = '0;
            latch = 1'b1;
            // en is only honoured at the frame boundary, so short dips are ignored.
            if (!en) state_d = StIdle;
          end else begin
            cy_d = cy_q + BIT_HEIGHT'(1);
          end
        end else begin
          cx_d = cx_q + BIT_WIDTH'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    if (latch) begin
      if (cfg_ok) begin
        h_act_d   = h_active;
        h_ss_d    = h_active + h_fp;
        h_se_d    = h_active + h_fp + h_sync;
        h_tot_d   = h_sum[BIT_WIDTH-1:0];
        v_act_d   = v_active;
        v_ss_d    = v_active + v_fp;
        v_se_d    = v_active + v_fp + v_sync;
        v_tot_d   = v_sum[BIT_HEIGHT-1:0];
        cfg_err_d = 1'b0;
      end else begin
        cfg_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge rtio_clk) begin
    if (!rtio_resetn) begin
      state_q   <= StIdle;
      cx_q      <= '0;
      cy_q      <= '0;
      h_act_q   <= HActRst;
      h_ss_q    <= HSsRst;
      h_se_q    <= HSeRst;
      h_tot_q   <= HTotRst;
      v_act_q   <= VActRst;
      v_ss_q    <= VSsRst;
      v_se_q    <= VSeRst;
      v_tot_q   <= VTotRst;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      h_act_q   <= h_act_d;
      h_ss_q    <= h_ss_d;
      h_se_q    <= h_se_d;
      h_tot_q   <= h_tot_d;
      v_act_q   <= v_act_d;
      v_ss_q    <= v_ss_d;
      v_se_q    <= v_se_d;
      v_tot_q   <= v_tot_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  logic [2:0] raw, dly;
  assign raw[2] = run && (cx_q < h_act_q) && (cy_q < v_act_q);
  assign raw[1] = run && (cx_q >= h_ss_q) && (cx_q < h_se_q);
  assign raw[0] = run && (cy_q >= v_ss_q) && (cy_q < v_se_q);

  // Pipeline carries active-high flags; polarity is applied at the output.
  if (PIPE_LAT == 0) begin : g_nopipe
    assign dly = raw;
  end else begin : g_pipe
    logic [2:0] pipe_q [PIPE_LAT];
    always_ff @(posedge rtio_clk) begin
      if (!rtio_resetn) begin
        for (int i = 0; i < int'(PIPE_LAT); i++) pipe_q[i] <= '0;
      end else begin
        pipe_q[0] <= raw;
        for (int i = 1; i < int'(PIPE_LAT); i++) pipe_q[i] <= pipe_q[i-1];
      end
    end
    assign dly = pipe_q[PIPE_LAT-1];
  end

  assign cx            = cx_q;
  assign cy            = cy_q;
  assign frame_width   = h_tot_q;
  assign frame_height  = v_tot_q;
  assign screen_width  = h_act_q;
  assign screen_height = v_act_q;
  assign de            = dly[2];
  assign hsync         = dly[1] ? SYNC_POL : ~SYNC_POL;
  assign vsync         = dly[0] ? SYNC_POL : ~SYNC_POL;
  assign frame_start   = run && (cx_q == '0) && (cy_q == '0);
  assign cfg_err       = cfg_err_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: two instances (zero-latency active-low syncs, default
// two-stage active-high) against a frame-index reference model.
module tb_video_timing_gen;
  localparam int W = 12;
  localparam int H = 11;

  logic rtio_clk = 1'b0;
  always #5 rtio_clk = ~rtio_clk;

  logic rtio_resetn, en;
  logic [W-1:0] h_active, h_fp, h_sync, h_bp;
  logic [H-1:0] v_active, v_fp, v_sync, v_bp;

  logic [W-1:0] d0_cx, d0_fw, d0_sw, d2_cx, d2_fw, d2_sw;
  logic [H-1:0] d0_cy, d0_fh, d0_sh, d2_cy, d2_fh, d2_sh;
  logic d0_de, d0_hs, d0_vs, d0_fs, d0_err, d2_de, d2_hs, d2_vs, d2_fs, d2_err;

  video_timing_gen #(.BIT_WIDTH(W), .BIT_HEIGHT(H), .PIPE_LAT(0), .SYNC_POL(1'b0)) dut0 (
    .rtio_clk(rtio_clk), .rtio_resetn(rtio_resetn), .en(en),
    .h_active(h_active), .h_fp(h_fp), .h_sync(h_sync), .h_bp(h_bp),
    .v_active(v_active), .v_fp(v_fp), .v_sync(v_sync), .v_bp(v_bp),
    .cx(d0_cx), .cy(d0_cy), .frame_width(d0_fw), .frame_height(d0_fh),
    .screen_width(d0_sw), .screen_height(d0_sh), .de(d0_de), .hsync(d0_hs),
    .vsync(d0_vs), .frame_start(d0_fs), .cfg_err(d0_err)
  );

  video_timing_gen dut2 (
    .rtio_clk(rtio_clk), .rtio_resetn(rtio_resetn), .en(en),
    .h_active(h_active), .h_fp(h_fp), .h_sync(h_sync), .h_bp(h_bp),
    .v_active(v_active), .v_fp(v_fp), .v_sync(v_sync), .v_bp(v_bp),
    .cx(d2_cx), .cy(d2_cy), .frame_width(d2_fw), .frame_height(d2_fh),
    .screen_width(d2_sw), .screen_height(d2_sh), .de(d2_de), .hsync(d2_hs),
    .vsync(d2_vs), .frame_start(d2_fs), .cfg_err(d2_err)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: linear pixel index within the frame plus latched field lengths.
  int m_run, m_pos, m_err;
  int c_ha, c_hf, c_hs, c_hb, c_va, c_vf, c_vs, c_vb;
  logic [2:0] hist[$];

  function automatic int htot(); return c_ha + c_hf + c_hs + c_hb; endfunction
  function automatic int vtot(); return c_va + c_vf + c_vs + c_vb; endfunction
  function automatic int m_cx(); return (m_run != 0) ? m_pos % htot() : 0; endfunction
  function automatic int m_cy(); return (m_run != 0) ? m_pos / htot() : 0; endfunction

  function automatic logic [2:0] raw_now();
    int x = m_cx();
    int y = m_cy();
    logic r = (m_run != 0);
    raw_now = {r && x < c_ha && y < c_va,
               r && x >= c_ha + c_hf && x < c_ha + c_hf + c_hs,
               r && y >= c_va + c_vf && y < c_va + c_vf + c_vs};
  endfunction

  task automatic try_latch();
    int hsum = int'(h_active) + int'(h_fp) + int'(h_sync) + int'(h_bp);
    int vsum = int'(v_active) + int'(v_fp) + int'(v_sync) + int'(v_bp);
    if (h_active == 0 || h_fp == 0 || h_sync == 0 || h_bp == 0 || v_active == 0 ||
        v_fp == 0 || v_sync == 0 || v_bp == 0 || hsum > 4095 || vsum > 2047) begin
      m_err = 1;
    end else begin
      c_ha = int'(h_active); c_hf = int'(h_fp); c_hs = int'(h_sync); c_hb = int'(h_bp);
      c_va = int'(v_active); c_vf = int'(v_fp); c_vs = int'(v_sync); c_vb = int'(v_bp);
      m_err = 0;
    end
  endtask

  task automatic model_edge();
    if (!rtio_resetn) begin
      m_run = 0; m_pos = 0; m_err = 0;
      c_ha = 1920; c_hf = 88; c_hs = 44; c_hb = 148;
      c_va = 1080; c_vf = 4; c_vs = 5; c_vb = 36;
      hist = '{3'b000, 3'b000};
    end else begin
      hist.push_back(raw_now());
      void'(hist.pop_front());
      if (m_run == 0) begin
        if (en) begin
          try_latch();
          m_run = 1;
          m_pos = 0;
        end
      end else begin
        m_pos++;
        if (m_pos == htot() * vtot()) begin
          m_pos = 0;
          try_latch();
          if (!en) m_run = 0;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [W-1:0] e_cx, e_fw, e_sw;
    logic [H-1:0] e_cy, e_fh, e_sh;
    logic [2:0]   r;
    logic         e_fs, e_err;
    @(posedge rtio_clk);
    model_edge();
    #1;
    e_cx = W'(m_cx()); e_cy = H'(m_cy());
    e_fw = W'(htot()); e_fh = H'(vtot()); e_sw = W'(c_ha); e_sh = H'(c_va);
    e_fs = (m_run != 0) && (m_pos == 0);
    e_err = (m_err != 0);
    r = raw_now();
    chk("d0_pos", {d0_cx, d0_cy, d0_fs, d0_err}, {e_cx, e_cy, e_fs, e_err});
    chk("d0_cfg", {d0_fw, d0_fh, d0_sw, d0_sh}, {e_fw, e_fh, e_sw, e_sh});
    chk("d0_strobe", {d0_de, d0_hs, d0_vs}, {r[2], ~r[1], ~r[0]});
    chk("d2_pos", {d2_cx, d2_cy, d2_fs, d2_err}, {e_cx, e_cy, e_fs, e_err});
    chk("d2_cfg", {d2_fw, d2_fh, d2_sw, d2_sh}, {e_fw, e_fh, e_sw, e_sh});
    chk("d2_strobe", {d2_de, d2_hs, d2_vs}, hist[0]);
  endtask

  task automatic wait_at(input int x, input int y);
    bit hit = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      if (m_run != 0 && m_cx() == x && m_cy() == y) hit = 1'b1;
      else tick();
    end
    chk("wait_at", {63'd0, hit}, 64'd1);
  endtask

  task automatic set_cfg(input int ha, hf, hs, hb, va, vf, vs, vb);
    h_active = W'(ha); h_fp = W'(hf); h_sync = W'(hs); h_bp = W'(hb);
    v_active = H'(va); v_fp = H'(vf); v_sync = H'(vs); v_bp = H'(vb);
  endtask

  function automatic int rnd_field();
    int v = int'($urandom_range(1, 4));
    if ($urandom_range(0, 9) == 0) v = 0;
    return v;
  endfunction

  initial begin
    rtio_resetn = 1'b0;
    en = 1'b0;
    set_cfg(4, 1, 1, 2, 3, 1, 1, 1);
    repeat (3) tick();
    rtio_resetn = 1'b1;
    en = 1'b1;
    repeat (150) tick();
    // Mid-frame width change takes effect on the next frame only.
    wait_at(2, 2);
    h_active = W'(6);
    repeat (120) tick();
    // Rejected config keeps frames running, then a valid one clears the flag.
    h_active = W'(4);
    h_fp = '0;
    repeat (70) tick();
    h_fp = W'(1);
    repeat (100) tick();
    // Stop at frame end, idle, then restart.
    wait_at(0, 1);
    en = 1'b0;
    repeat (80) tick();
    en = 1'b1;
    repeat (10) tick();
    // Brief en dip within a frame is ignored.
    wait_at(0, 1);
    en = 1'b0;
    repeat (2) tick();
    en = 1'b1;
    repeat (60) tick();
    // Oversized totals are rejected.
    set_cfg(4000, 100, 1, 2, 3, 1, 1, 1);
    repeat (60) tick();
    set_cfg(4, 1, 1, 2, 2040, 10, 1, 1);
    repeat (60) tick();
    set_cfg(4, 1, 1, 2, 3, 1, 1, 1);
    repeat (60) tick();
    // Mid-frame reset.
    wait_at(3, 2);
    rtio_resetn = 1'b0;
    tick();
    rtio_resetn = 1'b1;
    repeat (60) tick();
    // Randomized configs, enables and occasional resets.
    for (int it = 0; it < 40; it++) begin
      set_cfg(rnd_field(), rnd_field(), rnd_field(), rnd_field(),
              rnd_field(), rnd_field(), rnd_field(), rnd_field());
      en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) begin
        rtio_resetn = 1'b0;
        tick();
        rtio_resetn = 1'b1;
        set_cfg(int'($urandom_range(1, 4)), 1, 1, 1, int'($urandom_range(1, 3)), 1, 1, 1);
      end
      repeat (int'($urandom_range(10, 60))) tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 The module SHALL have parameter BIT_WIDTH, default 12, width of horizontal counters and fields.
REQ-002 The module SHALL have parameter BIT_HEIGHT, default 11, width of vertical counters and fields.
REQ-003 The module SHALL have parameter PIPE_LAT, default 2, range 0-7; delay of de/hsync/vsync behind cx/cy, matching downstream pixel latency.
REQ-004 The module SHALL have parameter SYNC_POL, default 1'b1; 1 = active-high syncs.
REQ-005 Ports, in order:
- rtio_clk  in  1  sole clock.
- rtio_resetn  in  1  reset; synchronous, active-low.
- en  in  1  run enable.
- h_active, h_fp, h_sync, h_bp  in  BIT_WIDTH each  horizontal field lengths in pixels.
- v_active, v_fp, v_sync, v_bp  in  BIT_HEIGHT each  vertical field lengths in lines.
- cx  out  BIT_WIDTH  current pixel column.
- cy  out  BIT_HEIGHT  current line.
- frame_width  out  BIT_WIDTH  latched horizontal total.
- frame_height  out  BIT_HEIGHT  latched vertical total.
- screen_width  out  BIT_WIDTH  latched h_active.
- screen_height  out  BIT_HEIGHT  latched v_active.
- de, hsync, vsync  out  1 each  delayed timing strobes.
- frame_start  out  1  one-cycle pulse at cx=0, cy=0.
- cfg_err  out  1  sticky flag: last latch attempt rejected.

Function
REQ-006 Totals: h_total = sum of four h fields, computed in BIT_WIDTH+2 bits; v_total = sum of four v fields, computed in BIT_HEIGHT+2 bits.
REQ-007 Config SHALL be latched only at frame boundary: first enabled cycle after idle, and the cycle cx wraps from h_total-1 while cy = v_total-1.
REQ-008 Latch SHALL be rejected, previous config kept and cfg_err set, if any field is 0, h_total > 2^BIT_WIDTH - 1, or v_total > 2^BIT_HEIGHT - 1.
REQ-009 On accepted latch, cfg_err SHALL clear, and frame_width, frame_height, screen_width and screen_height SHALL update in the same cycle cx=0, cy=0 is presented.
REQ-010 Sequence per line, in cx order: active [0, h_active-1], front porch, sync, back porch; vertical likewise, in cy order.
REQ-011 While running, cx SHALL increment every cycle and wrap to 0 after h_total-1; cy SHALL increment on each cx wrap and wrap to 0 after v_total-1.
REQ-012 de_raw = (cx < h_active) AND (cy < v_active).
REQ-013 hsync_raw SHALL be active for h_active+h_fp <= cx < h_active+h_fp+h_sync.
REQ-014 vsync_raw SHALL be active for v_active+v_fp <= cy < v_active+v_fp+v_sync, held for whole lines.
REQ-015 Raw strobes SHALL use latched config, and SHALL pass through exactly PIPE_LAT register stages to become de/hsync/vsync; sync level = SYNC_POL when active, else ~SYNC_POL.
REQ-016 frame_start SHALL be high for exactly the cycle cx=0, cy=0 is presented while running, with zero delay.
REQ-017 en deassert SHALL take effect at the next frame boundary: the frame completes, then cx=0, cy=0 are held, de_raw=0 and syncs are inactive.
REQ-018 en reasserted while idle SHALL start a frame on the following cycle.
REQ-019 The delay pipeline SHALL keep shifting while idle, so it drains to inactive values.
REQ-020 en toggled low then high within one frame SHALL cause no interruption.

Reset
REQ-021 With rtio_resetn=0 at a clock edge: cx=0, cy=0, idle, de=0, hsync=vsync=~SYNC_POL (whole pipeline), frame_start=0, cfg_err=0.
REQ-022 Reset config SHALL be h 1920/88/44/148 (frame_width 2200, screen_width 1920) and v 1080/4/5/36 (frame_height 1125, screen_height 1080).
REQ-023 Reset asserted mid-frame SHALL abort immediately; the first enabled cycle after release is a frame boundary.

Verification
REQ-024 Config h 4/1/1/2, v 3/1/1/1, PIPE_LAT=0, en=1 -> 48-cycle frame; de high for cx 0-3 on cy 0-2; hsync high only at cx=5; vsync high for all of cy=4; frame_start every 48 cycles.
REQ-025 Same config, PIPE_LAT=2 -> de/hsync/vsync identical to REQ-024 waveform shifted 2 cycles; cx/cy/frame_start unshifted.
REQ-026 Change h_active 4->6 mid-frame -> current frame keeps width 8; next frame has frame_width=10, screen_width=6.
REQ-027 h_fp=0 presented at boundary -> cfg_err=1, 48-cycle frames continue; valid config at next boundary -> cfg_err=0.
REQ-028 en dropped at cy=1 -> frame finishes through cy=5, cx=47th cycle, then cx=cy=0 and de=0 held; en=1 -> frame_start next cycle.
REQ-029 rtio_resetn=0 at cx=3, cy=2 -> all outputs at reset values next edge; frame_width=2200 after release.
